// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Bundle of the fetch controller's control, ROM and downstream
//                signals.
//                slave  - seen by fetch_ctrl (commands in, PC/IR/status out)
//                master - seen by whoever drives the controller (sequencer,
//                         instruction ROM model, testbench)
//  Signals     : Start/StartAddr   - launch fetching at an address
//                Stall             - downstream not ready, hold PC and IR
//                BranchEn/BranchRel/Target - redirect (absolute or relative)
//                InstIn            - ROM data for InstAddress (same cycle)
//                InstAddress       - PC, drives ROM address
//                IR/IRValid        - fetched instruction and its valid flag
//                Done              - halt fetched, machine stopped
//                CycleCount        - cycles spent running since last Start
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    logic        Start;
    logic [7:0]  StartAddr;
    logic        Stall;
    logic        BranchEn;
    logic        BranchRel;
    logic [7:0]  Target;
    logic [8:0]  InstIn;
    logic [7:0]  InstAddress;
    logic [8:0]  IR;
    logic        IRValid;
    logic        Done;
    logic [15:0] CycleCount;

    modport slave (
        input  Start, StartAddr, Stall, BranchEn, BranchRel, Target, InstIn,
        output InstAddress, IR, IRValid, Done, CycleCount
    );

    modport master (
        output Start, StartAddr, Stall, BranchEn, BranchRel, Target, InstIn,
        input  InstAddress, IR, IRValid, Done, CycleCount
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller. Walks a PC through an
//                instruction ROM, latches each fetched word into IR, honours
//                stall and branch (absolute / PC-relative) requests, and stops
//                when a halt opcode (InstIn[8:5] == 4'b1111) is fetched.
//  Ports       : Clk   - rising-edge clock
//                Reset - synchronous, active-high
//                bus   - fetch_ctrl_if.slave (see interface for signal list)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl (
    input  wire logic     Clk,
    input  wire logic     Reset,
    fetch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0]  c_HALT_OP   = 4'b1111;
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [8:0]  r_ir;
    logic        r_ir_valid;
    logic        r_done;
    logic [15:0] r_cycle_cnt;

    logic [7:0]  w_branch_pc;
    logic        w_is_halt;

    // An 8-bit add wraps mod 256, which is exactly PC + sign-extended offset.
    assign w_branch_pc = bus.BranchRel ? (r_pc + bus.Target) : bus.Target;
    assign w_is_halt   = (bus.InstIn[8:5] == c_HALT_OP);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_pc        <= 8'd0;
            r_ir        <= 9'd0;
            r_ir_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_cycle_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // Every edge spent running counts, stalled or not.
                    if (r_cycle_cnt != c_CNT_MAX) begin
                        r_cycle_cnt <= r_cycle_cnt + 16'd1;
                    end

                    if (bus.BranchEn) begin
                        // Redirect wins over stall; the word in flight is
                        // from the old path, so flush it.
                        r_pc       <= w_branch_pc;
                        r_ir_valid <= 1'b0;
                    end else if (bus.Stall) begin
                        r_pc       <= r_pc;
                    end else if (w_is_halt) begin
                        // Present the halt word downstream and freeze PC on it.
                        r_ir       <= bus.InstIn;
                        r_ir_valid <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= S_HALTED;
                    end else begin
                        r_ir       <= bus.InstIn;
                        r_ir_valid <= 1'b1;
                        r_pc       <= r_pc + 8'd1;
                    end
                end

                S_IDLE, S_HALTED: begin
                    if (bus.Start) begin
                        r_pc        <= bus.StartAddr;
                        r_ir        <= 9'd0;
                        r_ir_valid  <= 1'b0;
                        r_done      <= 1'b0;
                        r_cycle_cnt <= 16'd0;
                        r_state     <= S_RUN;
                    end else if (r_state == S_HALTED) begin
                        // The halt word is offered for exactly one cycle.
                        r_ir_valid  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.InstAddress = r_pc;
    assign bus.IR          = r_ir;
    assign bus.IRValid     = r_ir_valid;
    assign bus.Done        = r_done;
    assign bus.CycleCount  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high. Ports are named Clk and Reset.
REQ-002 Clk  input  1  rising-edge system clock.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Start  input  1  one-cycle pulse: begin fetching at StartAddr.
REQ-005 StartAddr  input  8  first instruction address.
REQ-006 Stall  input  1  downstream not ready: hold PC and IR.
REQ-007 BranchEn  input  1  downstream redirect request, valid this cycle.
REQ-008 BranchRel  input  1  1 = Target is signed offset from current PC; 0 = Target is absolute.
REQ-009 Target  input  8  branch address or two's-complement offset.
REQ-010 InstIn  input  9  instruction ROM data; combinational function of InstAddress in the same cycle.
REQ-011 InstAddress  output  8  PC, driven to the instruction ROM address.
REQ-012 IR  output  9  registered fetched instruction.
REQ-013 IRValid  output  1  IR holds a valid instruction for downstream.
REQ-014 Done  output  1  halt instruction fetched; machine stopped.
REQ-015 CycleCount  output  16  cycles spent in RUN since the last Start.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and HALTED; Reset enters IDLE.
REQ-017 IDLE/HALTED: Start=1 -> PC<=StartAddr, IR<=0, IRValid<=0, Done<=0, CycleCount<=0, state<=RUN; otherwise all registers hold.
REQ-018 RUN priority per cycle SHALL be BranchEn > Stall > halt detect > normal fetch; Start is ignored in RUN.
REQ-019 RUN, BranchEn=1 -> PC<=Target (absolute) or PC+sign-extended Target mod 256 (relative); IRValid<=0 (flush); applies even with Stall=1.
REQ-020 RUN, Stall=1, BranchEn=0 -> PC, IR, IRValid hold.
REQ-021 RUN, normal fetch -> IR<=InstIn, IRValid<=1, PC<=PC+1 mod 256 (255 wraps to 0).
REQ-022 Halt detect: InstIn[8:5]=4'b1111 with BranchEn=0, Stall=0 -> IR<=InstIn, IRValid<=1, PC holds, Done<=1, state<=HALTED.
REQ-023 HALTED: IRValid SHALL fall to 0 on the cycle after entry; PC, IR, Done hold until Start or Reset.
REQ-024 CycleCount SHALL increment by 1 on every clock edge spent in RUN, including stalled cycles, and saturate at 16'hFFFF.
REQ-025 Fetch latency: instruction at address A SHALL appear on IR one cycle after PC=A with no stall.
REQ-026 All outputs SHALL be registered except InstAddress, which equals the PC register.

Reset
REQ-027 Reset=1 at a rising edge SHALL force state=IDLE, PC=0, IR=0, IRValid=0, Done=0, CycleCount=0, overriding Start, BranchEn and Stall.
REQ-028 Reset asserted mid-RUN SHALL abort fetching with no further IR updates until the next Start.

Verification
REQ-029 Start=1, StartAddr=0, ROM {0:0x001,1:0x049,2:0x041,3:0x0C9,4:0x1FF} -> IR sequence 0x001,0x049,0x041,0x0C9,0x1FF on cycles 1-5; Done=1 after cycle 5, PC held at 4, CycleCount=5.
REQ-030 RUN with PC=3, BranchEn=1, BranchRel=0, Target=1 -> next PC=1, IRValid=0 for one cycle, then IR=ROM[1].
REQ-031 PC=5, BranchEn=1, BranchRel=1, Target=8'hFE -> PC=3; PC=8'hFF, normal fetch -> PC=0.
REQ-032 Stall=1 for 3 cycles at PC=2 -> PC=2 and IR unchanged throughout, CycleCount +3; Stall=1 with BranchEn=1, Target=7 -> PC=7.
REQ-033 Halt opcode fetched while BranchEn=1 -> branch taken, Done stays 0; Start=1 in HALTED with StartAddr=0x10 -> RUN, PC=0x10, Done=0, CycleCount=0.
REQ-034 Reset=1 mid-RUN with Start=1 and BranchEn=1 -> IDLE, PC=0, IRValid=0, Done=0, CycleCount=0 next cycle.
